player_status_manager: RTL
==========================

# player_status_manager

Collision-event consumer for the player: turns per-pixel collision strobes into per-frame game-state updates. It filters the pixel-rate strobes to at most one event per class per frame and maintains lives, a post-hit invulnerability window, a speed-boost timer and bomb capacity and usage. It sits between the collision controller and the character/bomb movement and HUD blocks.

## Interface
- INIT_LIVES, 3, lives after reset
- MAX_LIVES, 5, life saturation ceiling
- INVULN_FRAMES, 60, frames of hit immunity after a life is lost
- BOOST_FRAMES, 150, frames of speed boost per boots pickup
- INIT_BOMBS, 1, bomb capacity after reset
- MAX_BOMBS, 4, bomb capacity ceiling

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- startOfFrame  in  1  one-cycle pulse per frame
- decrease_life  in  1  pixel-rate hit strobe
- life_collected  in  1  pixel-rate life-pickup strobe
- boots_collected  in  1  pixel-rate boots-pickup strobe
- addBomb_collected  in  1  pixel-rate bomb-pickup strobe
- bomb_placed  in  1  one-cycle request to place a bomb
- bomb_returned  in  1  one-cycle pulse when an own bomb finishes exploding
- lives  out  3  current lives
- game_over  out  1  sticky; set when lives reach 0
- invulnerable  out  1  high in HIT state
- speed_boost  out  1  boost timer non-zero
- bomb_capacity  out  3  current capacity
- bombs_in_use  out  3  bombs currently placed
- can_place_bomb  out  1  bombs_in_use < bomb_capacity and not game_over
- life_lost_pulse  out  1  one-cycle pulse when a hit is applied

## Operation
- Latch stage: four pending flags (hit, life, boots, bomb). Each is set by its strobe on any cycle and cleared on the apply cycle.
- Apply cycle: the cycle where startOfFrame=1. The registered pending flags are applied and cleared. A strobe arriving in that same cycle sets its flag for the next frame; it is not lost.
- Lives FSM: ALIVE, HIT, DEAD.
  - ALIVE, pending hit → lives−1, life_lost_pulse, invuln counter=INVULN_FRAMES−1, go to HIT. If the result is 0 → DEAD instead.
  - HIT: the counter decrements on each apply cycle. When the counter is 0 on an apply cycle → ALIVE. Pending hits in HIT are discarded.
  - DEAD: game_over=1. All events are ignored and counters freeze. The only exit is reset.
- Same-frame life pickup and hit in ALIVE: the pickup is applied first, with saturation, then the decrement. Example: lives=MAX, pickup+hit → MAX−1.
- Life pickup: lives+1, saturating at MAX_LIVES. Applied in ALIVE and HIT.
- Boots pickup: boost timer reloads to BOOST_FRAMES; it does not accumulate. The timer decrements on each apply cycle while non-zero.
- Bomb pickup: bomb_capacity+1, saturating at MAX_BOMBS.
- Bomb accounting is evaluated every cycle, not frame-gated:
  - bomb_placed with can_place_bomb=1 → in_use+1; otherwise the request is ignored.
  - bomb_returned with in_use>0 → in_use−1; a return at in_use=0 is ignored.
  - Placed and returned in the same cycle → in_use unchanged, provided the placement was legal.
  - bombs_in_use never wraps.

## Timing
- Reset values: lives=INIT_LIVES, game_over=0, invulnerable=0, speed_boost=0, bomb_capacity=INIT_BOMBS, bombs_in_use=0, can_place_bomb=1, life_lost_pulse=0. Reset also sets state=ALIVE and clears all pending flags and timers.
- All outputs are registered, except can_place_bomb, which is combinational from registered state.
- Strobe to state update: effective on the first startOfFrame at least one cycle after the strobe. Outputs change on the cycle after that startOfFrame.
- life_lost_pulse is exactly one cycle wide, at most once per frame.
- Invulnerability length: invulnerable is high for exactly INVULN_FRAMES apply cycles. The hit's own apply cycle is not counted.
- Reset mid-frame or mid-HIT: pending events are discarded and all state returns to reset values on the next edge.

## Configuration
- PLAYER_STATUS_BOOST_EN defined: the boots pending flag and boost timer are implemented, and speed_boost behaves as above.
- Not defined: the boost timer and flag are removed, boots_collected is ignored, and speed_boost is tied to 0.

## Test plan
- Reset, then 500 cycles of decrease_life high, then one startOfFrame → lives 3→2, one life_lost_pulse, invulnerable=1.
- From the previous state, hit strobes on every frame for 60 frames → lives stay 2. invulnerable drops after the 60th following startOfFrame. The next hit frame gives lives=1.
- lives=5, life_collected and decrease_life in the same frame → lives=4. Life pickup only → lives stays 5.
- Three applied hits from reset with invulnerability expired between them → lives=0, game_over=1. Further pickups leave all outputs frozen until reset.
- Bomb accounting:
  - capacity=1: two bomb_placed pulses → in_use=1, second ignored, can_place_bomb=0.
  - bomb_returned → in_use=0.
  - Return at 0 → stays 0.
  - Same-cycle place and return with in_use=1, capacity=2 → stays 1.
- With PLAYER_STATUS_BOOST_EN defined:
  - boots_collected → speed_boost=1 for 150 frames.
  - Repeat pickup at frame 100 → reload to 150.
  - Macro undefined → speed_boost is always 0.

Source files
------------

// File: rtl/player_status_manager.sv
// rtl/player_status_manager.sv - per-frame player state from pixel-rate collision strobes
// Optional boost feature: define PLAYER_STATUS_BOOST_EN to build the boots flag and boost timer.
module player_status_manager #(
   parameter int INIT_LIVES    = 3,
   parameter int MAX_LIVES     = 5,
   parameter int INVULN_FRAMES = 60,
   parameter int BOOST_FRAMES  = 150,
   parameter int INIT_BOMBS    = 1,
   parameter int MAX_BOMBS     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       startOfFrame,
   input  logic       decrease_life,
   input  logic       life_collected,
   input  logic       boots_collected,
   input  logic       addBomb_collected,
   input  logic       bomb_placed,
   input  logic       bomb_returned,
   output logic [2:0] lives,
   output logic       game_over,
   output logic       invulnerable,
   output logic       speed_boost,
   output logic [2:0] bomb_capacity,
   output logic [2:0] bombs_in_use,
   output logic       can_place_bomb,
   output logic       life_lost_pulse
);

   localparam int IW = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;
   localparam logic [2:0]    INIT_L   = 3'(INIT_LIVES);
   localparam logic [2:0]    MAX_L    = 3'(MAX_LIVES);
   localparam logic [2:0]    INIT_B   = 3'(INIT_BOMBS);
   localparam logic [2:0]    MAX_B    = 3'(MAX_BOMBS);
   localparam logic [IW-1:0] INV_LAST = IW'(INVULN_FRAMES - 1);

   typedef enum logic [1:0] {ALIVE, HIT, DEAD} state_t;

   state_t        state;
   logic [IW-1:0] invuln_cnt;
   logic          pend_hit;
   logic          pend_life;
   logic          pend_bomb;
   logic [2:0]    lives_up;
   logic          frame_apply;
   logic          place_ok;
   logic          ret_ok;

   // Frame-gated updates only happen while the player is still in the game
   always_comb begin
      frame_apply = startOfFrame && (state != DEAD);
      lives_up    = (pend_life && (lives < MAX_L)) ? lives + 3'd1 : lives;
   end

   // Bomb legality is evaluated from registered state every cycle
   always_comb begin
      can_place_bomb = !game_over && (bombs_in_use < bomb_capacity);
      place_ok       = bomb_placed && can_place_bomb;
      ret_ok         = bomb_returned && (bombs_in_use != 3'd0);
   end

   // Pending flags: strobes accumulate until the apply cycle; a strobe on the apply cycle seeds the next frame
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_hit  <= 1'b0;
         pend_life <= 1'b0;
         pend_bomb <= 1'b0;
      end else if (startOfFrame) begin
         pend_hit  <= decrease_life;
         pend_life <= life_collected;
         pend_bomb <= addBomb_collected;
      end else begin
         pend_hit  <= pend_hit  | decrease_life;
         pend_life <= pend_life | life_collected;
         pend_bomb <= pend_bomb | addBomb_collected;
      end
   end

   // Lives FSM: pickup is applied before the hit so a full-health pickup+hit still costs a life
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ALIVE;
         lives           <= INIT_L;
         game_over       <= 1'b0;
         invulnerable    <= 1'b0;
         invuln_cnt      <= '0;
         life_lost_pulse <= 1'b0;
      end else begin
         life_lost_pulse <= 1'b0;
         if (frame_apply) begin
            lives <= lives_up;
            case (state)
               ALIVE: begin
                  if (pend_hit) begin
                     life_lost_pulse <= 1'b1;
                     lives           <= lives_up - 3'd1;
                     if (lives_up == 3'd1) begin
                        state     <= DEAD;
                        game_over <= 1'b1;
                     end else begin
                        state        <= HIT;
                        invulnerable <= 1'b1;
                        invuln_cnt   <= INV_LAST;
                     end
                  end
               end
               HIT: begin
                  if (invuln_cnt == '0) begin
                     state        <= ALIVE;
                     invulnerable <= 1'b0;
                  end else begin
                     invuln_cnt <= invuln_cnt - IW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Bomb capacity grows per frame; in-use count tracks placements and returns every cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         bomb_capacity <= INIT_B;
         bombs_in_use  <= 3'd0;
      end else if (state != DEAD) begin
         if (frame_apply && pend_bomb && (bomb_capacity < MAX_B))
            bomb_capacity <= bomb_capacity + 3'd1;
         if (place_ok && !ret_ok)
            bombs_in_use <= bombs_in_use + 3'd1;
         else if (ret_ok && !place_ok)
            bombs_in_use <= bombs_in_use - 3'd1;
      end
   end

`ifdef PLAYER_STATUS_BOOST_EN
   localparam int BW = $clog2(BOOST_FRAMES + 1);
   localparam logic [BW-1:0] BOOST_LOAD = BW'(BOOST_FRAMES);

   logic          pend_boots;
   logic [BW-1:0] boost_cnt;

   // Boost timer: a pickup reloads rather than accumulates; speed_boost mirrors the next timer value
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_boots  <= 1'b0;
         boost_cnt   <= '0;
         speed_boost <= 1'b0;
      end else begin
         pend_boots <= startOfFrame ? boots_collected : (pend_boots | boots_collected);
         if (frame_apply) begin
            if (pend_boots) begin
               boost_cnt   <= BOOST_LOAD;
               speed_boost <= 1'b1;
            end else if (boost_cnt != '0) begin
               boost_cnt   <= boost_cnt - BW'(1);
               speed_boost <= (boost_cnt != BW'(1));
            end
         end
      end
   end
`else
   logic unused_boots;
   assign unused_boots = boots_collected;
   assign speed_boost  = 1'b0;
`endif

endmodule
